mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// One transaction is outstanding at a time; completion acks are steered combinationally to the owner.
module mem_arbiter #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [XLEN-1:0]   i_addr,
   output logic [XLEN-1:0]   i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [XLEN/8-1:0] d_be,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_ack,
   output logic              m_req,
   output logic              m_we,
   output logic [XLEN-1:0]   m_addr,
   output logic [XLEN-1:0]   m_wdata,
   output logic [XLEN/8-1:0] m_be,
   input  logic [XLEN-1:0]   m_rdata,
   input  logic              m_ack
);
   localparam int BEW = XLEN / 8;

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;
   typedef enum logic {LG_I, LG_D} grant_e;

   state_e            state_q;
   grant_e            last_grant_q;
   logic              m_req_q;
   logic              m_we_q;
   logic [XLEN-1:0]   m_addr_q;
   logic [XLEN-1:0]   m_wdata_q;
   logic [BEW-1:0]    m_be_q;
   logic              pick_i;

   // Instruction wins when alone, or on a tie when data was served last.
   assign pick_i = i_req && (!d_req || (last_grant_q == LG_D));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= LG_D;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_be_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_i) begin
                  state_q      <= GRANT_I;
                  last_grant_q <= LG_I;
                  m_req_q      <= 1'b1;
                  m_we_q       <= 1'b0;
                  m_addr_q     <= i_addr;
                  m_wdata_q    <= '0;
                  m_be_q       <= '1;
               end else if (d_req) begin
                  state_q      <= GRANT_D;
                  last_grant_q <= LG_D;
                  m_req_q      <= 1'b1;
                  m_we_q       <= d_we;
                  m_addr_q     <= d_addr;
                  m_wdata_q    <= d_wdata;
                  m_be_q       <= d_be;
               end
            end
            // Return to IDLE on ack; arbitration happens only from IDLE so a held req is not reissued.
            GRANT_I, GRANT_D: begin
               if (m_ack) begin
                  state_q <= IDLE;
                  m_req_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               m_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_be    = m_be_q;

   assign i_ack   = reset_n && (state_q == GRANT_I) && m_ack;
   assign d_ack   = reset_n && (state_q == GRANT_D) && m_ack;
   assign i_rdata = i_ack ? m_rdata : '0;
   assign d_rdata = d_ack ? m_rdata : '0;

endmodule
